// File: rtl/relogio_display.sv
// relogio_display: multiplexed 8-digit HH-MM-SS driver for an active-low 7-segment display.
// The time fields are snapshotted once per scan frame so that a frame never mixes two times.
// The field chosen by modo_ajuste_i blinks so the user can see which field inc/dec will adjust.
module relogio_display #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 50000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] segundos_i,
  input  logic [5:0] minutos_i,
  input  logic [5:0] horas_i,
  input  logic [1:0] modo_ajuste_i,
  output logic [7:0] an_o,
  output logic [7:0] seg_o,
  output logic       frame_o
);

  localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [ScanW-1:0]  ScanLast  = ScanW'(SCAN_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);
  localparam logic [7:0]        SegDash   = 8'hBF;
  localparam logic [7:0]        SegOff    = 8'hFF;

  logic [ScanW-1:0]  scan_cnt_q;
  logic [2:0]        idx_q;
  logic [BlinkW-1:0] blink_cnt_q;
  logic              blink_phase_q;
  logic [1:0]        modo_q;
  logic [5:0]        h_q, m_q, s_q;
  logic [7:0]        an_q, seg_q, an_d, seg_d;
  logic              frame_q;
  logic              scan_term, blink_term, modo_chg, in_field;

  assign scan_term  = (scan_cnt_q == ScanLast);
  assign blink_term = (blink_cnt_q == BlinkLast);
  assign modo_chg   = (modo_ajuste_i != modo_q);

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] units_of(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd0:    c = 8'hC0;
      4'd1:    c = 8'hF9;
      4'd2:    c = 8'hA4;
      4'd3:    c = 8'hB0;
      4'd4:    c = 8'h99;
      4'd5:    c = 8'h92;
      4'd6:    c = 8'h82;
      4'd7:    c = 8'hF8;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h90;
      default: c = SegOff;
    endcase
    return c;
  endfunction

  // Digit scan: advance one slot per SCAN_DIV cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
    end else if (scan_term) begin
      scan_cnt_q <= '0;
      idx_q      <= idx_q + 3'd1;
    end else begin
      scan_cnt_q <= scan_cnt_q + 1'b1;
    end
  end

  // Snapshot the time fields at the frame wrap and flag the new frame for one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q     <= '0;
      m_q     <= '0;
      s_q     <= '0;
      frame_q <= 1'b0;
    end else begin
      frame_q <= scan_term && (idx_q == 3'd7);
      if (scan_term && (idx_q == 3'd7)) begin
        h_q <= horas_i;
        m_q <= minutos_i;
        s_q <= segundos_i;
      end
    end
  end

  // Blink timebase; a mode change restarts it so the new field starts visible.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      modo_q        <= 2'b00;
    end else begin
      modo_q <= modo_ajuste_i;
      if (modo_chg) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= 1'b0;
      end else if (blink_term) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  // Select the segment pattern for the current slot and apply blanking of the adjusted field.
  always_comb begin
    seg_d = SegDash;
    an_d  = ~(8'b1 << idx_q);
    unique case (idx_q)
      3'd0: seg_d = seg_code(units_of(s_q));
      3'd1: seg_d = seg_code(tens_of(s_q));
      3'd3: seg_d = seg_code(units_of(m_q));
      3'd4: seg_d = seg_code(tens_of(m_q));
      3'd6: seg_d = seg_code(units_of(h_q));
      3'd7: seg_d = seg_code(tens_of(h_q));
      default: seg_d = SegDash;
    endcase
    case (modo_q)
      2'b01:   in_field = (idx_q[2:1] == 2'b11);
      2'b10:   in_field = (idx_q == 3'd3) || (idx_q == 3'd4);
      2'b11:   in_field = (idx_q[2:1] == 2'b00);
      default: in_field = 1'b0;
    endcase
    if (blink_phase_q && in_field) begin
      an_d  = SegOff;
      seg_d = SegOff;
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      an_q  <= 8'hFF;
      seg_q <= 8'hFF;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_relogio_display.sv
// Bench for relogio_display: per-cycle scoreboard against a behavioural model, table-driven
// frame contents checked against hand-derived segment codes, and hand-written corner sequences.
module tb_relogio_display;

  localparam int unsigned SD = 4;
  localparam int unsigned BD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] s_in = '0, m_in = '0, h_in = '0;
  logic [1:0] modo = 2'b00;
  logic [7:0] an, seg;
  logic       frame;

  relogio_display #(
    .SCAN_DIV (SD),
    .BLINK_DIV(BD)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .segundos_i   (s_in),
    .minutos_i    (m_in),
    .horas_i      (h_in),
    .modo_ajuste_i(modo),
    .an_o         (an),
    .seg_o        (seg),
    .frame_o      (frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
    logic       frame;
  } out_t;

  typedef struct {
    logic [5:0] h, m, s;
    logic [7:0] exp_seg[8];
  } vec_t;

  out_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Behavioural model state
  int         m_scan = 0, m_idx = 0, m_bcnt = 0;
  bit         m_phase = 0;
  logic [5:0] m_h = 0, m_m = 0, m_s = 0;
  logic [1:0] m_modo = 0;

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Compute what the DUT should present after the coming edge, then advance the model.
  task automatic model_step();
    out_t o;
    int   digit;
    bit   dash;
    bit   blank;
    digit = 0;
    dash  = 0;
    if (rst) begin
      o.an = 8'hFF; o.seg = 8'hFF; o.frame = 1'b0;
      m_scan = 0; m_idx = 0; m_bcnt = 0; m_phase = 0;
      m_h = 0; m_m = 0; m_s = 0; m_modo = 0;
    end else begin
      case (m_idx)
        0: digit = m_s % 10;
        1: digit = m_s / 10;
        3: digit = m_m % 10;
        4: digit = m_m / 10;
        6: digit = m_h % 10;
        7: digit = m_h / 10;
        default: dash = 1;
      endcase
      blank = m_phase && ((m_modo == 2'd1 && m_idx >= 6) ||
                          (m_modo == 2'd2 && (m_idx == 3 || m_idx == 4)) ||
                          (m_modo == 2'd3 && m_idx <= 1));
      o.an    = blank ? 8'hFF : ~(8'b1 << m_idx);
      o.seg   = blank ? 8'hFF : (dash ? 8'hBF : seg_of(digit));
      o.frame = (m_scan == SD - 1) && (m_idx == 7);
      if (modo != m_modo) begin
        m_bcnt = 0; m_phase = 0;
      end else if (m_bcnt == BD - 1) begin
        m_bcnt = 0; m_phase = ~m_phase;
      end else begin
        m_bcnt++;
      end
      m_modo = modo;
      if (m_scan == SD - 1) begin
        m_scan = 0;
        if (m_idx == 7) begin
          m_h = h_in; m_m = m_in; m_s = s_in;
        end
        m_idx = (m_idx + 1) % 8;
      end else begin
        m_scan++;
      end
    end
    exp_q.push_back(o);
  endtask

  task automatic tick();
    out_t o;
    model_step();
    @(posedge clk);
    #1;
    o = exp_q.pop_front();
    check("sb_an", an, o.an);
    check("sb_seg", seg, o.seg);
    check("sb_frame", {7'b0, frame}, {7'b0, o.frame});
  endtask

  task automatic wait_frame(output bit found);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (frame === 1'b1) found = 1;
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_timeout: got no frame_o pulse want one within 40 cycles");
    end
  endtask

  task automatic wait_an(input logic [7:0] target, input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      tick();
      if (an === target) found = 1;
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got an=%h want an=%h within 64 cycles", name, an, target);
    end
  endtask

  vec_t vecs[4];

  initial begin
    bit         ok;
    int         blanks;
    logic [7:0] exp_an;

    vecs[0].h = 23; vecs[0].m = 45; vecs[0].s = 7;
    vecs[0].exp_seg = '{8'hF8, 8'hC0, 8'hBF, 8'h92, 8'h99, 8'hBF, 8'hB0, 8'hA4};
    vecs[1].h = 63; vecs[1].m = 59; vecs[1].s = 63;
    vecs[1].exp_seg = '{8'hB0, 8'h82, 8'hBF, 8'h90, 8'h92, 8'hBF, 8'hB0, 8'h82};
    vecs[2].h = 0; vecs[2].m = 0; vecs[2].s = 0;
    vecs[2].exp_seg = '{8'hC0, 8'hC0, 8'hBF, 8'hC0, 8'hC0, 8'hBF, 8'hC0, 8'hC0};
    vecs[3].h = 12; vecs[3].m = 38; vecs[3].s = 16;
    vecs[3].exp_seg = '{8'h82, 8'hF9, 8'hBF, 8'h80, 8'hB0, 8'hBF, 8'hA4, 8'hF9};

    // Reset held for three cycles, then the scan walks from the rightmost digit.
    rst = 1'b1;
    repeat (3) tick();
    check("rst_an", an, 8'hFF);
    check("rst_seg", seg, 8'hFF);
    rst = 1'b0;
    tick();
    check("rel_an", an, 8'hFE);
    check("rel_seg", seg, 8'hC0);
    for (int k = 0; k < 16; k++) begin
      exp_an = ~(8'b1 << (k % 8));
      check("walk_an", an, exp_an);
      repeat (SD) tick();
    end

    // Frame contents per input set; inputs are scrambled mid-frame to prove no tearing.
    for (int v = 0; v < 4; v++) begin
      h_in = vecs[v].h; m_in = vecs[v].m; s_in = vecs[v].s; modo = 2'b00;
      wait_frame(ok);
      if (ok) begin
        tick();
        for (int k = 0; k < 8; k++) begin
          exp_an = ~(8'b1 << k);
          check("tbl_an", an, exp_an);
          check("tbl_seg", seg, vecs[v].exp_seg[k]);
          if (k == 4) begin
            h_in = 6'($urandom_range(63)); m_in = 6'($urandom_range(63));
            s_in = 6'($urandom_range(63));
          end
          repeat (SD) tick();
        end
      end
    end

    // Hours blinking.
    h_in = 23; m_in = 45; s_in = 7; modo = 2'b01;
    blanks = 0;
    for (int i = 0; i < 128; i++) begin
      tick();
      if (an === 8'hFF) blanks++;
    end
    check("blink_seen", 8'(blanks > 0), 8'd1);

    // Switch to minutes while hours are blanked: display stays visible for a full half-period.
    wait_an(8'hFF, "hours_blank_timeout");
    modo = 2'b10;
    tick();
    blanks = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (an === 8'hFF) blanks++;
    end
    check("switch_visible", 8'(blanks), 8'd0);
    repeat (64) tick();

    // Out-of-range seconds with no field selected: nothing ever blanks.
    modo = 2'b00; s_in = 63;
    repeat (2) tick();
    blanks = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (an === 8'hFF) blanks++;
    end
    check("noadj_noblank", 8'(blanks), 8'd0);

    // Reset in the middle of a frame.
    wait_an(8'hDF, "idx5_timeout");
    rst = 1'b1;
    tick();
    check("midrst_an", an, 8'hFF);
    check("midrst_seg", seg, 8'hFF);
    check("midrst_frame", {7'b0, frame}, 8'd0);
    rst = 1'b0;
    tick();
    check("post_rst_an", an, 8'hFE);
    check("post_rst_seg", seg, 8'hC0);
    repeat (SD) tick();
    check("post_rst_an1", an, 8'hFD);
    check("post_rst_seg1", seg, 8'hC0);
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
